// File: rtl/execute_csr_pipe.sv
// CSR execute unit: reads the CSR file with a configurable latency, computes the
// CSRRW/CSRRS/CSRRC result and access exception, and holds a writeback pack
// under valid/ready. Only one instruction is in flight at a time.
module execute_csr_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int ROB_ID_WIDTH   = 5,
    parameter int PHY_ID_WIDTH   = 6,
    parameter int READ_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iss_valid,
    output logic                      iss_pop,
    input  logic [CSR_ADDR_WIDTH-1:0] iss_csr,
    input  logic [1:0]                iss_op,
    input  logic [DATA_WIDTH-1:0]     iss_src1,
    input  logic                      iss_src1_zero,
    input  logic                      iss_rd_en,
    input  logic [PHY_ID_WIDTH-1:0]   iss_rd_phy,
    input  logic [ROB_ID_WIDTH-1:0]   iss_rob_id,
    input  logic [31:0]               iss_inst,
    output logic [CSR_ADDR_WIDTH-1:0] csrf_addr,
    input  logic [DATA_WIDTH-1:0]     csrf_data,
    input  logic                      csr_rd_ok,
    input  logic                      csr_wr_ok,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [ROB_ID_WIDTH-1:0]   wb_rob_id,
    output logic                      wb_rd_en,
    output logic [PHY_ID_WIDTH-1:0]   wb_rd_phy,
    output logic [DATA_WIDTH-1:0]     wb_rd_value,
    output logic [CSR_ADDR_WIDTH-1:0] wb_csr,
    output logic                      wb_new_valid,
    output logic [DATA_WIDTH-1:0]     wb_new_value,
    output logic                      wb_exc,
    output logic [31:0]               wb_exc_value,
    output logic                      fb_enable,
    output logic [PHY_ID_WIDTH-1:0]   fb_phy_id,
    output logic [DATA_WIDTH-1:0]     fb_value,
    input  logic                      flush
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    localparam logic [1:0] OP_RW = 2'd0;
    localparam logic [1:0] OP_RS = 2'd1;
    localparam logic [1:0] OP_RC = 2'd2;
    localparam logic [2:0] LAT_M1 = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_t                    state;
    logic [2:0]                count;
    logic [CSR_ADDR_WIDTH-1:0] lat_csr;
    logic [1:0]                lat_op;
    logic [DATA_WIDTH-1:0]     lat_src1;
    logic                      lat_src1_zero;
    logic                      lat_rd_en;
    logic [PHY_ID_WIDTH-1:0]   lat_rd_phy;
    logic [ROB_ID_WIDTH-1:0]   lat_rob_id;
    logic [31:0]               lat_inst;

    // With zero latency the result is formed straight from the issue head,
    // otherwise from the fields captured at pop time.
    logic                      use_iss;
    logic [1:0]                sel_op;
    logic [DATA_WIDTH-1:0]     sel_src1;
    logic                      sel_src1_zero;
    logic [31:0]               sel_inst;
    logic                      wr_intent;
    logic                      exc;
    logic [31:0]               exc_value;
    logic [DATA_WIDTH-1:0]     new_value;
    logic                      new_valid;
    logic                      load_wb;

    assign iss_pop       = (state == IDLE) && iss_valid && !flush && !rst;
    assign csrf_addr     = (state == IDLE) ? iss_csr : lat_csr;
    assign use_iss       = (state == IDLE);
    assign sel_op        = use_iss ? iss_op        : lat_op;
    assign sel_src1      = use_iss ? iss_src1      : lat_src1;
    assign sel_src1_zero = use_iss ? iss_src1_zero : lat_src1_zero;
    assign sel_inst      = use_iss ? iss_inst      : lat_inst;

    assign load_wb = ((state == IDLE) && iss_pop && (READ_LATENCY == 0)) ||
                     ((state == READ) && !flush && (count == 3'd0));

    assign fb_enable = wb_valid && wb_ready && wb_rd_en && !wb_exc && !flush;
    assign fb_phy_id = wb_rd_phy;
    assign fb_value  = wb_rd_value;

    // Access check, exception value and CSR update value for the sampled read.
    always_comb begin
        wr_intent = (sel_op == OP_RW) || !sel_src1_zero;
        exc       = !csr_rd_ok || (wr_intent && !csr_wr_ok) || (sel_op == 2'd3);
        exc_value = csr_rd_ok ? sel_inst : 32'd0;
        case (sel_op)
            OP_RW:   new_value = sel_src1;
            OP_RS:   new_value = csrf_data | sel_src1;
            OP_RC:   new_value = csrf_data & ~sel_src1;
            default: new_value = csrf_data;
        endcase
        new_valid = wr_intent && csr_wr_ok && !exc;
    end

    // Control FSM: captures the issue head, counts down the read latency and
    // holds the writeback pack until it is accepted or flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= 3'd0;
            lat_csr       <= '0;
            lat_op        <= 2'd0;
            lat_src1      <= '0;
            lat_src1_zero <= 1'b0;
            lat_rd_en     <= 1'b0;
            lat_rd_phy    <= '0;
            lat_rob_id    <= '0;
            lat_inst      <= 32'd0;
            wb_valid      <= 1'b0;
            wb_rob_id     <= '0;
            wb_rd_en      <= 1'b0;
            wb_rd_phy     <= '0;
            wb_rd_value   <= '0;
            wb_csr        <= '0;
            wb_new_valid  <= 1'b0;
            wb_new_value  <= '0;
            wb_exc        <= 1'b0;
            wb_exc_value  <= 32'd0;
        end else begin
            if (load_wb) begin
                wb_valid     <= 1'b1;
                wb_rob_id    <= use_iss ? iss_rob_id : lat_rob_id;
                wb_rd_en     <= use_iss ? iss_rd_en  : lat_rd_en;
                wb_rd_phy    <= use_iss ? iss_rd_phy : lat_rd_phy;
                wb_csr       <= csrf_addr;
                wb_rd_value  <= csrf_data;
                wb_new_valid <= new_valid;
                wb_new_value <= new_value;
                wb_exc       <= exc;
                wb_exc_value <= exc_value;
            end
            case (state)
                IDLE: begin
                    if (iss_pop) begin
                        lat_csr       <= iss_csr;
                        lat_op        <= iss_op;
                        lat_src1      <= iss_src1;
                        lat_src1_zero <= iss_src1_zero;
                        lat_rd_en     <= iss_rd_en;
                        lat_rd_phy    <= iss_rd_phy;
                        lat_rob_id    <= iss_rob_id;
                        lat_inst      <= iss_inst;
                        count         <= LAT_M1;
                        state         <= (READ_LATENCY == 0) ? RESP : READ;
                    end
                end
                READ: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (count == 3'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                RESP: begin
                    if (flush || wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_csr_pipe.sv
// Directed bench for execute_csr_pipe: four instances with read latencies
// 0, 1, 3 and 7 share one stimulus; most checks look at the latency-1 copy.
module tb_execute_csr_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [11:0] iss_csr;
    logic [1:0]  iss_op;
    logic [31:0] iss_src1;
    logic        iss_src1_zero;
    logic        iss_rd_en;
    logic [5:0]  iss_rd_phy;
    logic [4:0]  iss_rob_id;
    logic [31:0] iss_inst;
    logic [31:0] csrf_data;
    logic        csr_rd_ok;
    logic        csr_wr_ok;
    logic        wb_ready;
    logic        flush;

    logic        iss_pop_a      [4];
    logic [11:0] csrf_addr_a    [4];
    logic        wb_valid_a     [4];
    logic [4:0]  wb_rob_id_a    [4];
    logic        wb_rd_en_a     [4];
    logic [5:0]  wb_rd_phy_a    [4];
    logic [31:0] wb_rd_value_a  [4];
    logic [11:0] wb_csr_a       [4];
    logic        wb_new_valid_a [4];
    logic [31:0] wb_new_value_a [4];
    logic        wb_exc_a       [4];
    logic [31:0] wb_exc_value_a [4];
    logic        fb_enable_a    [4];
    logic [5:0]  fb_phy_id_a    [4];
    logic [31:0] fb_value_a     [4];

    int compared   = 0;
    int mismatched = 0;
    int lat_tab    [4] = '{0, 1, 3, 7};
    int first_seen [4];
    int second_seen[4];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        execute_csr_pipe #(
            .READ_LATENCY((k == 0) ? 0 : ((k == 1) ? 1 : ((k == 2) ? 3 : 7)))
        ) dut (
            .clk(clk), .rst(rst),
            .iss_valid(iss_valid), .iss_pop(iss_pop_a[k]),
            .iss_csr(iss_csr), .iss_op(iss_op), .iss_src1(iss_src1),
            .iss_src1_zero(iss_src1_zero), .iss_rd_en(iss_rd_en),
            .iss_rd_phy(iss_rd_phy), .iss_rob_id(iss_rob_id), .iss_inst(iss_inst),
            .csrf_addr(csrf_addr_a[k]), .csrf_data(csrf_data),
            .csr_rd_ok(csr_rd_ok), .csr_wr_ok(csr_wr_ok),
            .wb_valid(wb_valid_a[k]), .wb_ready(wb_ready),
            .wb_rob_id(wb_rob_id_a[k]), .wb_rd_en(wb_rd_en_a[k]),
            .wb_rd_phy(wb_rd_phy_a[k]), .wb_rd_value(wb_rd_value_a[k]),
            .wb_csr(wb_csr_a[k]), .wb_new_valid(wb_new_valid_a[k]),
            .wb_new_value(wb_new_value_a[k]), .wb_exc(wb_exc_a[k]),
            .wb_exc_value(wb_exc_value_a[k]),
            .fb_enable(fb_enable_a[k]), .fb_phy_id(fb_phy_id_a[k]),
            .fb_value(fb_value_a[k]), .flush(flush)
        );
    end

    // Advance one clock and land safely after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op,
                                 input logic [11:0] csr, input logic [31:0] src1,
                                 input logic zero, input logic [5:0] phy,
                                 input logic [4:0] rob, input logic [31:0] inst,
                                 input logic [31:0] data, input logic rok,
                                 input logic wok, input logic rdy);
        iss_valid = v; iss_op = op; iss_csr = csr; iss_src1 = src1;
        iss_src1_zero = zero; iss_rd_en = 1'b1; iss_rd_phy = phy;
        iss_rob_id = rob; iss_inst = inst; csrf_data = data;
        csr_rd_ok = rok; csr_wr_ok = wok; wb_ready = rdy;
    endtask

    // Pop on the current cycle, then stop issuing and move to the RESP cycle
    // of the latency-1 instance.
    task automatic toResp();
        tick();
        iss_valid = 1'b0;
        tick();
        #1;
    endtask

    task automatic drain();
        iss_valid = 1'b0; wb_ready = 1'b1; flush = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        applyStimulus(1'b0, 2'd0, 12'h0, 32'h0, 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        #1;
        checkOutput("reset_wb_valid", 64'(wb_valid_a[1]), 64'h0);
        checkOutput("reset_iss_pop", 64'(iss_pop_a[1]), 64'h0);
        checkOutput("reset_fb_enable", 64'(fb_enable_a[1]), 64'h0);
        checkOutput("reset_rd_value", 64'(wb_rd_value_a[1]), 64'h0);
        checkOutput("reset_exc", 64'(wb_exc_a[1]), 64'h0);
        rst = 1'b0;
        tick();

        // csrrs 0x300: old 0x8 | 0x2 -> 0xA, two cycles from pop to wb_valid
        applyStimulus(1'b1, 2'd1, 12'h300, 32'h2, 1'b0, 6'd5, 5'd3, 32'h30012573, 32'h8, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("rs_pop", 64'(iss_pop_a[1]), 64'h1);
        tick();
        iss_valid = 1'b0; iss_csr = 12'h0;
        #1;
        checkOutput("rs_read_wb_valid", 64'(wb_valid_a[1]), 64'h0);
        checkOutput("rs_read_csrf_addr", 64'(csrf_addr_a[1]), 64'h300);
        tick();
        #1;
        checkOutput("rs_wb_valid", 64'(wb_valid_a[1]), 64'h1);
        checkOutput("rs_rd_value", 64'(wb_rd_value_a[1]), 64'h8);
        checkOutput("rs_new_value", 64'(wb_new_value_a[1]), 64'hA);
        checkOutput("rs_new_valid", 64'(wb_new_valid_a[1]), 64'h1);
        checkOutput("rs_exc", 64'(wb_exc_a[1]), 64'h0);
        checkOutput("rs_rob_id", 64'(wb_rob_id_a[1]), 64'h3);
        checkOutput("rs_rd_phy", 64'(wb_rd_phy_a[1]), 64'h5);
        checkOutput("rs_wb_csr", 64'(wb_csr_a[1]), 64'h300);
        checkOutput("rs_fb_enable", 64'(fb_enable_a[1]), 64'h1);
        checkOutput("rs_fb_value", 64'(fb_value_a[1]), 64'h8);
        checkOutput("rs_lat0_new_value", 64'(wb_new_value_a[0]), 64'hA);
        tick();
        #1;
        checkOutput("rs_after_hs_valid", 64'(wb_valid_a[1]), 64'h0);
        drain();

        // csrrc with zero mask on read-only 0xF14: a pure read, no exception
        applyStimulus(1'b1, 2'd2, 12'hF14, 32'h0, 1'b1, 6'd7, 5'd4, 32'hF1403573, 32'h1234, 1'b1, 1'b0, 1'b1);
        toResp();
        checkOutput("ro_read_exc", 64'(wb_exc_a[1]), 64'h0);
        checkOutput("ro_read_new_valid", 64'(wb_new_valid_a[1]), 64'h0);
        checkOutput("ro_read_rd_value", 64'(wb_rd_value_a[1]), 64'h1234);
        checkOutput("ro_read_fb_enable", 64'(fb_enable_a[1]), 64'h1);
        drain();

        // csrrw on read-only 0xF14: illegal, exc_value is the instruction
        applyStimulus(1'b1, 2'd0, 12'hF14, 32'h55, 1'b0, 6'd8, 5'd5, 32'hF1459073, 32'h1234, 1'b1, 1'b0, 1'b1);
        toResp();
        checkOutput("ro_write_exc", 64'(wb_exc_a[1]), 64'h1);
        checkOutput("ro_write_exc_value", 64'(wb_exc_value_a[1]), 64'hF1459073);
        checkOutput("ro_write_new_valid", 64'(wb_new_valid_a[1]), 64'h0);
        checkOutput("ro_write_fb_enable", 64'(fb_enable_a[1]), 64'h0);
        drain();

        // Unimplemented CSR: exception with zero exc_value even for a pure read
        applyStimulus(1'b1, 2'd1, 12'h7C0, 32'h0, 1'b1, 6'd9, 5'd6, 32'h7C002573, 32'h0, 1'b0, 1'b0, 1'b1);
        toResp();
        checkOutput("unimpl_exc", 64'(wb_exc_a[1]), 64'h1);
        checkOutput("unimpl_exc_value", 64'(wb_exc_value_a[1]), 64'h0);
        drain();

        // Reserved op encoding is illegal even with full access
        applyStimulus(1'b1, 2'd3, 12'h340, 32'h1, 1'b0, 6'd10, 5'd7, 32'h34001073, 32'h9, 1'b1, 1'b1, 1'b1);
        toResp();
        checkOutput("op3_exc", 64'(wb_exc_a[1]), 64'h1);
        checkOutput("op3_exc_value", 64'(wb_exc_value_a[1]), 64'h34001073);
        checkOutput("op3_new_valid", 64'(wb_new_valid_a[1]), 64'h0);
        drain();

        // Back-pressure: csrrc 0xFF & ~0x0F held for 5 cycles, then accepted
        applyStimulus(1'b1, 2'd2, 12'h340, 32'h0F, 1'b0, 6'd11, 5'd8, 32'h3407B073, 32'hFF, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("stall_pop", 64'(iss_pop_a[1]), 64'h1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall_wb_valid", 64'(wb_valid_a[1]), 64'h1);
            checkOutput("stall_new_value", 64'(wb_new_value_a[1]), 64'hF0);
            checkOutput("stall_rob_id", 64'(wb_rob_id_a[1]), 64'h8);
            checkOutput("stall_no_pop", 64'(iss_pop_a[1]), 64'h0);
            tick();
        end
        wb_ready = 1'b1;
        #1;
        checkOutput("stall_hs_fb_enable", 64'(fb_enable_a[1]), 64'h1);
        checkOutput("stall_hs_no_pop", 64'(iss_pop_a[1]), 64'h0);
        tick();
        #1;
        checkOutput("stall_idle_valid", 64'(wb_valid_a[1]), 64'h0);
        checkOutput("stall_next_pop", 64'(iss_pop_a[1]), 64'h1);
        iss_valid = 1'b0;
        drain();

        // Flush while reading drops the instruction
        applyStimulus(1'b1, 2'd0, 12'h340, 32'h5, 1'b0, 6'd12, 5'd9, 32'h34029073, 32'h3, 1'b1, 1'b1, 1'b1);
        tick();
        iss_valid = 1'b0; flush = 1'b1;
        #1;
        checkOutput("flush_read_fb", 64'(fb_enable_a[1]), 64'h0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush_read_valid", 64'(wb_valid_a[1]), 64'h0);
        tick();
        #1;
        checkOutput("flush_read_later_valid", 64'(wb_valid_a[1]), 64'h0);
        iss_valid = 1'b1;
        #1;
        checkOutput("flush_read_idle_pop", 64'(iss_pop_a[1]), 64'h1);
        iss_valid = 1'b0;
        drain();

        // Flush in RESP beats a simultaneous wb_ready
        applyStimulus(1'b1, 2'd0, 12'h340, 32'h6, 1'b0, 6'd13, 5'd10, 32'h34031073, 32'h4, 1'b1, 1'b1, 1'b1);
        toResp();
        checkOutput("flush_resp_pre_valid", 64'(wb_valid_a[1]), 64'h1);
        flush = 1'b1;
        #1;
        checkOutput("flush_resp_fb", 64'(fb_enable_a[1]), 64'h0);
        tick();
        flush = 1'b0; iss_valid = 1'b1;
        #1;
        checkOutput("flush_resp_valid", 64'(wb_valid_a[1]), 64'h0);
        checkOutput("flush_resp_idle_pop", 64'(iss_pop_a[1]), 64'h1);
        iss_valid = 1'b0;
        drain();

        // Flush in IDLE blocks the pop
        iss_valid = 1'b1; flush = 1'b1;
        #1;
        checkOutput("flush_idle_pop", 64'(iss_pop_a[1]), 64'h0);
        checkOutput("flush_idle_pop_lat0", 64'(iss_pop_a[0]), 64'h0);
        iss_valid = 1'b0; flush = 1'b0;
        drain();

        // Latency sweep on back-to-back csrrw: first pack LAT+1 after the pop,
        // the next one LAT+2 later
        applyStimulus(1'b1, 2'd0, 12'h340, 32'h77, 1'b0, 6'd14, 5'd11, 32'h34079073, 32'h11, 1'b1, 1'b1, 1'b1);
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("sweep_pop", 64'(iss_pop_a[k]), 64'h1);
            first_seen[k]  = -1;
            second_seen[k] = -1;
        end
        for (int n = 1; n <= 30; n++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (wb_valid_a[k] === 1'b1) begin
                    if (first_seen[k] < 0) first_seen[k] = n;
                    else if (second_seen[k] < 0) second_seen[k] = n;
                end
            end
        end
        iss_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("sweep_first", 64'(first_seen[k]), 64'(lat_tab[k] + 1));
            checkOutput("sweep_second", 64'(second_seen[k]), 64'(2 * lat_tab[k] + 3));
        end
        drain();

        // Reset in RESP (latency 1) and mid-READ (latency 7)
        applyStimulus(1'b1, 2'd1, 12'h340, 32'h10, 1'b0, 6'd15, 5'd12, 32'h34082073, 32'hABC, 1'b1, 1'b1, 1'b0);
        tick();
        iss_valid = 1'b0; iss_csr = 12'h0;
        tick();
        #1;
        checkOutput("rst_pre_valid", 64'(wb_valid_a[1]), 64'h1);
        checkOutput("rst_pre_addr7", 64'(csrf_addr_a[3]), 64'h340);
        rst = 1'b1;
        tick();
        #1;
        checkOutput("rst_valid", 64'(wb_valid_a[1]), 64'h0);
        checkOutput("rst_rd_value", 64'(wb_rd_value_a[1]), 64'h0);
        checkOutput("rst_new_value", 64'(wb_new_value_a[1]), 64'h0);
        checkOutput("rst_rob_id", 64'(wb_rob_id_a[1]), 64'h0);
        checkOutput("rst_fb_enable", 64'(fb_enable_a[1]), 64'h0);
        checkOutput("rst_addr7", 64'(csrf_addr_a[3]), 64'h0);
        checkOutput("rst_valid7", 64'(wb_valid_a[3]), 64'h0);
        rst = 1'b0;
        repeat (10) tick();
        #1;
        checkOutput("rst_discard7", 64'(wb_valid_a[3]), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
